// File: rtl/hazard_control_unit.sv
// Decode-side hazard controller: load-use stall insertion and taken-branch flush sequencing.
// Optional performance counters are enabled by defining HAZARD_PERF_COUNTERS_EN.
module hazard_control_unit #(
  parameter int REG_ADDR_WIDTH      = 4,
  parameter int LOAD_LATENCY        = 1,
  parameter int BRANCH_FLUSH_CYCLES = 1
`ifdef HAZARD_PERF_COUNTERS_EN
  ,
  parameter int CNT_WIDTH           = 16
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_decode,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_decode,
  input  logic                      uses_rs1_decode,
  input  logic                      uses_rs2_decode,
  input  logic [REG_ADDR_WIDTH-1:0] rd_execute,
  input  logic                      wre_execute,
  input  logic                      mem_read_execute,
  input  logic                      branch_taken_execute,
  output logic                      stall_fetch,
  output logic                      stall_decode,
  output logic                      flush_decode,
  output logic                      flush_execute,
  output logic [1:0]                hazard_state
`ifdef HAZARD_PERF_COUNTERS_EN
  ,
  output logic [CNT_WIDTH-1:0]      load_stall_count,
  output logic [CNT_WIDTH-1:0]      branch_flush_count
`endif
);

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    LOAD_STALL   = 2'b01,
    BRANCH_FLUSH = 2'b10
  } state_t;

  // Single-cycle sequences stay in IDLE; longer ones park in a holding state.
  localparam state_t     BR_NEXT = (BRANCH_FLUSH_CYCLES > 1) ? BRANCH_FLUSH : IDLE;
  localparam logic [2:0] BR_CNT  = (BRANCH_FLUSH_CYCLES > 1) ? 3'(BRANCH_FLUSH_CYCLES - 1) : 3'd0;
  localparam state_t     LD_NEXT = (LOAD_LATENCY > 1) ? LOAD_STALL : IDLE;
  localparam logic [2:0] LD_CNT  = (LOAD_LATENCY > 1) ? 3'(LOAD_LATENCY - 1) : 3'd0;

  state_t     state_r;
  state_t     state_nxt_s;
  logic [2:0] cnt_r;
  logic [2:0] cnt_nxt_s;
  logic       load_use_s;
  logic       stall_s;
  logic       flush_dec_s;
  logic       flush_exe_s;

  assign load_use_s = mem_read_execute & wre_execute &
                      ((uses_rs1_decode & (rs1_decode == rd_execute)) |
                       (uses_rs2_decode & (rs2_decode == rd_execute)));

  // State and counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 3'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state and raw stall/flush decode.
  always_comb begin
    state_nxt_s = IDLE;
    cnt_nxt_s   = 3'd0;
    stall_s     = 1'b0;
    flush_dec_s = 1'b0;
    flush_exe_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (branch_taken_execute) begin
          flush_dec_s = 1'b1;
          flush_exe_s = 1'b1;
          state_nxt_s = BR_NEXT;
          cnt_nxt_s   = BR_CNT;
        end else if (load_use_s) begin
          stall_s     = 1'b1;
          flush_exe_s = 1'b1;
          state_nxt_s = LD_NEXT;
          cnt_nxt_s   = LD_CNT;
        end else begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 3'd0;
        end
      end
      LOAD_STALL: begin
        // A taken branch makes the stalled instruction wrong-path, so it wins.
        if (branch_taken_execute) begin
          flush_dec_s = 1'b1;
          flush_exe_s = 1'b1;
          state_nxt_s = BR_NEXT;
          cnt_nxt_s   = BR_CNT;
        end else begin
          stall_s     = 1'b1;
          flush_exe_s = 1'b1;
          if (cnt_r <= 3'd1) begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = 3'd0;
          end else begin
            state_nxt_s = LOAD_STALL;
            cnt_nxt_s   = cnt_r - 3'd1;
          end
        end
      end
      BRANCH_FLUSH: begin
        flush_dec_s = 1'b1;
        flush_exe_s = 1'b1;
        if (cnt_r <= 3'd1) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 3'd0;
        end else begin
          state_nxt_s = BRANCH_FLUSH;
          cnt_nxt_s   = cnt_r - 3'd1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 3'd0;
      end
    endcase
  end

  // Reset forces every output quiet in the same cycle so no residual stall escapes.
  assign stall_fetch   = stall_s & ~rst;
  assign stall_decode  = stall_s & ~rst;
  assign flush_decode  = flush_dec_s & ~rst;
  assign flush_execute = flush_exe_s & ~rst;
  assign hazard_state  = rst ? 2'b00 : state_r;

`ifdef HAZARD_PERF_COUNTERS_EN
  logic [CNT_WIDTH-1:0] load_stall_count_r;
  logic [CNT_WIDTH-1:0] branch_flush_count_r;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_stall_count_r   <= {CNT_WIDTH{1'b0}};
      branch_flush_count_r <= {CNT_WIDTH{1'b0}};
    end else begin
      if (stall_fetch && !(&load_stall_count_r)) begin
        load_stall_count_r <= load_stall_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        load_stall_count_r <= load_stall_count_r;
      end
      if (flush_decode && !(&branch_flush_count_r)) begin
        branch_flush_count_r <= branch_flush_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        branch_flush_count_r <= branch_flush_count_r;
      end
    end
  end

  assign load_stall_count   = load_stall_count_r;
  assign branch_flush_count = branch_flush_count_r;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench: two instances (LOAD_LATENCY=3/BRANCH_FLUSH_CYCLES=2 and 1/1),
// vector table, then random stimulus against a cycle-count reference model.
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] rs1 = 4'd0, rs2 = 4'd0, rd = 4'd0;
  logic       u1 = 1'b0, u2 = 1'b0, wre = 1'b0, mr = 1'b0, br = 1'b0;

  logic       sf3, sd3, fd3, fe3, sf1, sd1, fd1, fe1;
  logic [1:0] hs3, hs1;
`ifdef HAZARD_PERF_COUNTERS_EN
  logic [1:0] lsc3, bfc3, lsc1, bfc1;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_control_unit #(.REG_ADDR_WIDTH(4), .LOAD_LATENCY(3), .BRANCH_FLUSH_CYCLES(2)
`ifdef HAZARD_PERF_COUNTERS_EN
    , .CNT_WIDTH(2)
`endif
  ) dut3 (
    .clk(clk), .rst(rst), .rs1_decode(rs1), .rs2_decode(rs2),
    .uses_rs1_decode(u1), .uses_rs2_decode(u2), .rd_execute(rd),
    .wre_execute(wre), .mem_read_execute(mr), .branch_taken_execute(br),
    .stall_fetch(sf3), .stall_decode(sd3), .flush_decode(fd3), .flush_execute(fe3),
    .hazard_state(hs3)
`ifdef HAZARD_PERF_COUNTERS_EN
    , .load_stall_count(lsc3), .branch_flush_count(bfc3)
`endif
  );

  hazard_control_unit #(.REG_ADDR_WIDTH(4), .LOAD_LATENCY(1), .BRANCH_FLUSH_CYCLES(1)
`ifdef HAZARD_PERF_COUNTERS_EN
    , .CNT_WIDTH(2)
`endif
  ) dut1 (
    .clk(clk), .rst(rst), .rs1_decode(rs1), .rs2_decode(rs2),
    .uses_rs1_decode(u1), .uses_rs2_decode(u2), .rd_execute(rd),
    .wre_execute(wre), .mem_read_execute(mr), .branch_taken_execute(br),
    .stall_fetch(sf1), .stall_decode(sd1), .flush_decode(fd1), .flush_execute(fe1),
    .hazard_state(hs1)
`ifdef HAZARD_PERF_COUNTERS_EN
    , .load_stall_count(lsc1), .branch_flush_count(bfc1)
`endif
  );

  typedef enum int {P_IDLE, P_LU1, P_LU2, P_NOUSE2, P_ALU, P_NOWRE, P_BR, P_BRLU, P_R0} pat_t;

  typedef struct {
    logic       rst;
    pat_t       pat;
    logic [3:0] exp3;  // {stall_fetch, stall_decode, flush_decode, flush_execute}
    logic [1:0] st3;
    logic [3:0] exp1;
    logic [1:0] st1;
  } vec_t;

  localparam logic [3:0] O_NONE  = 4'b0000;
  localparam logic [3:0] O_STALL = 4'b1101;
  localparam logic [3:0] O_FLUSH = 4'b0011;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input pat_t p, input logic [3:0] e3, input logic [1:0] s3,
                     input logic [3:0] e1, input logic [1:0] s1);
    vec_t v;
    v.rst = r; v.pat = p; v.exp3 = e3; v.st3 = s3; v.exp1 = e1; v.st1 = s1;
    vecs.push_back(v);
  endtask

  task automatic apply_pat(input logic r, input pat_t p);
    rst = r; rs1 = 4'd1; rs2 = 4'd2; rd = 4'd7;
    u1 = 1'b0; u2 = 1'b0; wre = 1'b0; mr = 1'b0; br = 1'b0;
    case (p)
      P_LU1:    begin mr = 1'b1; wre = 1'b1; rd = 4'h3; rs1 = 4'h3; u1 = 1'b1; end
      P_LU2:    begin mr = 1'b1; wre = 1'b1; rd = 4'h5; rs2 = 4'h5; u2 = 1'b1; rs1 = 4'h9; u1 = 1'b1; end
      P_NOUSE2: begin mr = 1'b1; wre = 1'b1; rd = 4'h5; rs2 = 4'h5; u2 = 1'b0; rs1 = 4'h0; u1 = 1'b1; end
      P_ALU:    begin mr = 1'b0; wre = 1'b1; rd = 4'h3; rs1 = 4'h3; u1 = 1'b1; end
      P_NOWRE:  begin mr = 1'b1; wre = 1'b0; rd = 4'h3; rs1 = 4'h3; u1 = 1'b1; end
      P_BR:     begin br = 1'b1; end
      P_BRLU:   begin mr = 1'b1; wre = 1'b1; rd = 4'h3; rs1 = 4'h3; u1 = 1'b1; br = 1'b1; end
      P_R0:     begin mr = 1'b1; wre = 1'b1; rd = 4'h0; rs1 = 4'h0; u1 = 1'b1; end
      default:  begin end
    endcase
  endtask

  // Reference model: remaining stall/flush cycles per instance.
  int rem_stall[2] = '{0, 0};
  int rem_flush[2] = '{0, 0};
  int m_ls[2]      = '{0, 0};
  int m_bf[2]      = '{0, 0};

  task automatic model_step(input int i, input int ll, input int bfc,
                            output logic [3:0] o, output logic [1:0] st);
    bit lu;
    lu = mr && wre && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    o = O_NONE; st = 2'b00;
    if (rst) begin
      rem_stall[i] = 0; rem_flush[i] = 0;
    end else if (rem_flush[i] > 0) begin
      o = O_FLUSH; st = 2'b10; rem_flush[i]--;
    end else if (br) begin
      o = O_FLUSH; st = (rem_stall[i] > 0) ? 2'b01 : 2'b00;
      rem_stall[i] = 0; rem_flush[i] = bfc - 1;
    end else if (rem_stall[i] > 0) begin
      o = O_STALL; st = 2'b01; rem_stall[i]--;
    end else if (lu) begin
      o = O_STALL; rem_stall[i] = ll - 1;
    end
  endtask

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  initial begin
    logic [3:0] o3, o1;
    logic [1:0] s3, s1;

    add(1'b1, P_LU1,    O_NONE,  2'b00, O_NONE,  2'b00);
    add(1'b0, P_IDLE,   O_NONE,  2'b00, O_NONE,  2'b00);
    add(1'b0, P_LU1,    O_STALL, 2'b00, O_STALL, 2'b00);
    add(1'b0, P_IDLE,   O_STALL, 2'b01, O_NONE,  2'b00);
    add(1'b0, P_IDLE,   O_STALL, 2'b01, O_NONE,  2'b00);
    add(1'b0, P_IDLE,   O_NONE,  2'b00, O_NONE,  2'b00);
    add(1'b0, P_NOUSE2, O_NONE,  2'b00, O_NONE,  2'b00);
    add(1'b0, P_ALU,    O_NONE,  2'b00, O_NONE,  2'b00);
    add(1'b0, P_NOWRE,  O_NONE,  2'b00, O_NONE,  2'b00);
    add(1'b0, P_LU2,    O_STALL, 2'b00, O_STALL, 2'b00);
    add(1'b0, P_IDLE,   O_STALL, 2'b01, O_NONE,  2'b00);
    add(1'b0, P_BR,     O_FLUSH, 2'b01, O_FLUSH, 2'b00);
    add(1'b0, P_LU1,    O_FLUSH, 2'b10, O_STALL, 2'b00);
    add(1'b0, P_BRLU,   O_FLUSH, 2'b00, O_FLUSH, 2'b00);
    add(1'b0, P_BR,     O_FLUSH, 2'b10, O_FLUSH, 2'b00);
    add(1'b0, P_IDLE,   O_NONE,  2'b00, O_NONE,  2'b00);
    add(1'b0, P_LU1,    O_STALL, 2'b00, O_STALL, 2'b00);
    add(1'b1, P_IDLE,   O_NONE,  2'b00, O_NONE,  2'b00);
    add(1'b0, P_IDLE,   O_NONE,  2'b00, O_NONE,  2'b00);
    add(1'b0, P_R0,     O_STALL, 2'b00, O_STALL, 2'b00);
    add(1'b0, P_IDLE,   O_STALL, 2'b01, O_NONE,  2'b00);
    add(1'b1, P_IDLE,   O_NONE,  2'b00, O_NONE,  2'b00);
    add(1'b0, P_IDLE,   O_NONE,  2'b00, O_NONE,  2'b00);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      apply_pat(vecs[i].rst, vecs[i].pat);
      @(negedge clk);
      check($sformatf("vec%0d dut3 outs", i), {28'd0, sf3, sd3, fd3, fe3}, {28'd0, vecs[i].exp3});
      check($sformatf("vec%0d dut3 state", i), {30'd0, hs3}, {30'd0, vecs[i].st3});
      check($sformatf("vec%0d dut1 outs", i), {28'd0, sf1, sd1, fd1, fe1}, {28'd0, vecs[i].exp1});
      check($sformatf("vec%0d dut1 state", i), {30'd0, hs1}, {30'd0, vecs[i].st1});
    end

    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      rst = (c == 0) || ($urandom_range(0, 39) == 0);
      rs1 = 4'($urandom_range(0, 3)); rs2 = 4'($urandom_range(0, 3)); rd = 4'($urandom_range(0, 3));
      u1 = 1'($urandom); u2 = 1'($urandom); wre = 1'($urandom); mr = 1'($urandom);
      br = ($urandom_range(0, 5) == 0);
      @(negedge clk);
`ifdef HAZARD_PERF_COUNTERS_EN
      check($sformatf("rnd%0d dut3 load_stall_count", c), {30'd0, lsc3}, 32'(sat3(m_ls[0])));
      check($sformatf("rnd%0d dut3 branch_flush_count", c), {30'd0, bfc3}, 32'(sat3(m_bf[0])));
      check($sformatf("rnd%0d dut1 load_stall_count", c), {30'd0, lsc1}, 32'(sat3(m_ls[1])));
      check($sformatf("rnd%0d dut1 branch_flush_count", c), {30'd0, bfc1}, 32'(sat3(m_bf[1])));
`endif
      model_step(0, 3, 2, o3, s3);
      model_step(1, 1, 1, o1, s1);
      check($sformatf("rnd%0d dut3 outs", c), {28'd0, sf3, sd3, fd3, fe3}, {28'd0, o3});
      check($sformatf("rnd%0d dut3 state", c), {30'd0, hs3}, {30'd0, s3});
      check($sformatf("rnd%0d dut1 outs", c), {28'd0, sf1, sd1, fd1, fe1}, {28'd0, o1});
      check($sformatf("rnd%0d dut1 state", c), {30'd0, hs1}, {30'd0, s1});
      if (rst) begin
        m_ls = '{0, 0}; m_bf = '{0, 0};
      end else begin
        m_ls[0] += int'(o3[3]); m_bf[0] += int'(o3[1]);
        m_ls[1] += int'(o1[3]); m_bf[1] += int'(o1[1]);
      end
    end

`ifdef HAZARD_PERF_COUNTERS_EN
    // Five isolated load-use events: 2-bit counters must pin at 3.
    @(posedge clk); #1; apply_pat(1'b1, P_IDLE);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1; apply_pat(1'b0, P_LU1);
      for (int g = 0; g < 3; g++) begin
        @(posedge clk); #1; apply_pat(1'b0, P_IDLE);
      end
    end
    @(negedge clk);
    check("sat dut1 load_stall_count", {30'd0, lsc1}, 32'd3);
    check("sat dut3 load_stall_count", {30'd0, lsc3}, 32'd3);
    check("sat dut1 branch_flush_count", {30'd0, bfc1}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
